calc_eval_core: RTL and testbench
=================================

CALC_EVAL_CORE -- requirements
Module: calc_eval_core

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width in bits.
REQ-002 Parameter DEPTH, default 8, operand stack entries (power of two, >= 2).
REQ-003 Parameter ALU_TIMEOUT, default 255, maximum cycles waited for al_done.
REQ-004 Clock  input  1  clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 tok_valid  input  1  token offered.
REQ-007 tok_ready  output  1  token accepted when tok_valid and tok_ready are both high on a rising edge.
REQ-008 tok_kind  input  2  00 number, 01 binary op, 10 negate, 11 clear.
REQ-009 tok_op  input  2  binary op: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 tok_data  input  DATA_W  number value for kind 00.
REQ-011 al_A, al_B  output  DATA_W each  ALU operands (A = second-from-top, B = top).
REQ-012 al_cmd  output  2  ALU op code, same encoding as tok_op.
REQ-013 al_start  output  1  one-cycle ALU start pulse.
REQ-014 al_done, al_C  input  1, DATA_W  ALU completion strobe and result.
REQ-015 res_valid, res_data  output  1, DATA_W  stack non-empty flag and top-of-stack value.
REQ-016 level  output  clog2(DEPTH)+1  current stack occupancy.
REQ-017 err  output  2  00 none, 01 overflow, 10 underflow, 11 div-by-zero or ALU timeout.

Function
REQ-018 FSM states: IDLE, EXEC, WAIT. tok_ready is high only in IDLE.
REQ-019 Number accepted, level < DEPTH: push tok_data at the next edge; level increments by 1.
REQ-020 Number accepted, level == DEPTH: err <= 01; stack unchanged.
REQ-021 Binary op accepted, level < 2: err <= 10; stack unchanged; remain IDLE.
REQ-022 Div accepted, top == 0: err <= 11; stack unchanged; ALU not started.
REQ-023 Other binary op accepted: latch op into al_cmd; go to EXEC.
REQ-024 EXEC: al_start = 1 for exactly one cycle; then WAIT.
REQ-025 al_A, al_B, al_cmd stay stable from EXEC until the cycle al_done is sampled.
REQ-026 al_done is sampled in EXEC and WAIT. On al_done: al_C is written to entry level-2, level decrements by 1, FSM returns to IDLE.
REQ-027 WAIT counter: counts cycles in WAIT. On reaching ALU_TIMEOUT without al_done: err <= 11, stack unchanged, return to IDLE.
REQ-028 Negate accepted, level >= 1: top <= two's complement (0 - top) modulo 2^DATA_W in one cycle; FSM stays in IDLE.
REQ-029 Negate accepted, level == 0: err <= 10.
REQ-030 Clear accepted: level <= 0 and err <= 00 at the next edge, in any err condition.
REQ-031 err is sticky. While err != 00, number, op and negate tokens are accepted and discarded with no stack change.
REQ-032 Error-setting events never alter the stack or level.
REQ-033 res_valid = (level != 0); res_data = top entry when res_valid = 1, else 0; both combinational from state.
REQ-034 All ALU arithmetic is external; the block does no width extension; al_C is stored as delivered.
REQ-035 al_done outside EXEC/WAIT is ignored.

Reset
REQ-036 On Reset low, immediately: FSM = IDLE, level = 0, err = 00, al_start = 0, al_cmd = 00, al_A = al_B = 0, WAIT counter = 0, res_valid = 0, res_data = 0.
REQ-037 Stack contents need not be cleared; they are unobservable while level = 0.
REQ-038 Reset asserted during EXEC/WAIT aborts the operation. A later al_done has no effect.

Verification
REQ-039 Push 7, push 5, op sub, ALU returns al_C = 2 three cycles after al_start:
        al_A = 7, al_B = 5, al_cmd = 01, single al_start pulse; afterwards level = 1, res_data = 2, tok_ready low until return to IDLE.
REQ-040 DEPTH = 8: push 9 values; 9th push -> err = 01, level = 8, res_data = 8th value.
        Then push -> discarded; clear -> level = 0, err = 00.
REQ-041 Push 4, push 0, op div -> err = 11, al_start never asserted, level = 2.
        Push 1, op add (level 1) after clear -> err = 10.
REQ-042 ALU_TIMEOUT = 4, op add with al_done held low -> err = 11 after 4 WAIT cycles, level unchanged, tok_ready high.
REQ-043 Push 0x00000003, negate -> res_data = 0xFFFFFFFD.
        Reset asserted in WAIT -> level = 0, al_start = 0; a late al_done leaves level = 0.

Source files
------------

// File: rtl/calc_eval_core_if.sv
// Token and ALU bus for calc_eval_core.
//
// Handshake: a token transfers on a rising Clock edge where tok_valid and
// tok_ready are both high. The producer holds tok_kind/tok_op/tok_data
// stable while tok_valid is high. tok_ready never depends on tok_valid.
//
// ALU side: al_start pulses for one cycle with al_A/al_B/al_cmd valid.
// The operands stay stable until al_done is seen. al_done qualifies al_C
// for one cycle.
//
// Modports:
//   master - token producer plus external ALU (testbench / system side)
//   slave  - calc_eval_core
interface calc_eval_core_if #(
    parameter int DATA_W = 32
);
    logic              tok_valid;
    logic              tok_ready;
    logic [1:0]        tok_kind;
    logic [1:0]        tok_op;
    logic [DATA_W-1:0] tok_data;
    logic [DATA_W-1:0] al_A;
    logic [DATA_W-1:0] al_B;
    logic [1:0]        al_cmd;
    logic              al_start;
    logic              al_done;
    logic [DATA_W-1:0] al_C;

    modport master (
        output tok_valid, tok_kind, tok_op, tok_data, al_done, al_C,
        input  tok_ready, al_A, al_B, al_cmd, al_start
    );

    modport slave (
        input  tok_valid, tok_kind, tok_op, tok_data, al_done, al_C,
        output tok_ready, al_A, al_B, al_cmd, al_start
    );
endinterface

// File: rtl/calc_eval_core.sv
// RPN expression evaluator core: an operand stack fed by tokens, with
// binary operations delegated to an external ALU.
//
// Ports:
//   Clock, Reset - rising-edge clock, asynchronous active-low reset
//   bus          - token handshake and ALU bus (calc_eval_core_if.slave)
//   res_valid    - stack non-empty
//   res_data     - top of stack (0 when empty)
//   level        - stack occupancy
//   err          - 00 none, 01 overflow, 10 underflow, 11 div-by-zero/timeout
//   state_dbg    - current FSM state (IDLE/EXEC/WAIT)
module calc_eval_core #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic                     Clock,
    input  logic                     Reset,
    calc_eval_core_if.slave          bus,
    output logic                     res_valid,
    output logic [DATA_W-1:0]        res_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               err,
    output logic [1:0]               state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [1:0] K_NUM = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_NEG = 2'b10;
    localparam logic [1:0] K_CLR = 2'b11;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_OVF  = 2'b01;
    localparam logic [1:0] E_UNF  = 2'b10;
    localparam logic [1:0] E_ALU  = 2'b11;

    logic [1:0]        state;
    logic [TW-1:0]     wait_cnt;
    logic [DATA_W-1:0] stk [DEPTH];

    logic [LW-1:0]     lvl_m1;
    logic [LW-1:0]     lvl_m2;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     sec_idx;
    logic [DATA_W-1:0] top_val;
    logic [DATA_W-1:0] sec_val;
    logic              accept;
    logic              full;
    logic              alu_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign lvl_m1  = level - LW'(1);
    assign lvl_m2  = level - LW'(2);
    assign top_idx = lvl_m1[AW-1:0];
    assign sec_idx = lvl_m2[AW-1:0];
    assign top_val = stk[top_idx];
    assign sec_val = stk[sec_idx];

    assign bus.tok_ready = (state == IDLE);
    assign bus.al_start  = (state == EXEC);
    assign accept        = bus.tok_valid && (state == IDLE);
    assign full          = (level == LW'(DEPTH));
    assign alu_busy      = (state == EXEC) || (state == WAIT);

    assign res_valid = (level != '0);
    assign res_data  = res_valid ? top_val : '0;
    assign state_dbg = state;

    // Stack write port: push, in-place negate, or ALU result. The three
    // sources are mutually exclusive because tokens are only taken in IDLE.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (accept && err == E_NONE && bus.tok_kind == K_NUM && !full) begin
            wr_en   = 1'b1;
            wr_idx  = level[AW-1:0];
            wr_data = bus.tok_data;
        end else if (accept && err == E_NONE && bus.tok_kind == K_NEG && res_valid) begin
            wr_en   = 1'b1;
            wr_idx  = top_idx;
            wr_data = '0 - top_val;
        end else if (alu_busy && bus.al_done) begin
            wr_en   = 1'b1;
            wr_idx  = sec_idx;
            wr_data = bus.al_C;
        end
    end

    // Stack storage carries no reset; entries above level are never visible.
    always_ff @(posedge Clock) begin
        if (wr_en) stk[wr_idx] <= wr_data;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            level      <= '0;
            err        <= E_NONE;
            wait_cnt   <= '0;
            bus.al_cmd <= 2'b00;
            bus.al_A   <= '0;
            bus.al_B   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.tok_kind == K_CLR) begin
                            level <= '0;
                            err   <= E_NONE;
                        end else if (err == E_NONE) begin
                            case (bus.tok_kind)
                                K_NUM: begin
                                    if (full) err <= E_OVF;
                                    else      level <= level + LW'(1);
                                end
                                K_OP: begin
                                    if (level < LW'(2)) begin
                                        err <= E_UNF;
                                    end else if (bus.tok_op == 2'b11 && top_val == '0) begin
                                        err <= E_ALU;
                                    end else begin
                                        bus.al_cmd <= bus.tok_op;
                                        bus.al_A   <= sec_val;
                                        bus.al_B   <= top_val;
                                        state      <= EXEC;
                                    end
                                end
                                K_NEG: begin
                                    if (!res_valid) err <= E_UNF;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    if (bus.al_done) begin
                        level <= lvl_m1;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A done arriving on the final counted cycle still wins.
                    if (bus.al_done) begin
                        level    <= lvl_m1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt == TW'(ALU_TIMEOUT - 1)) begin
                        err      <= E_ALU;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_eval_core.sv
module tb_calc_eval_core;
    localparam int DW = 32;

    logic          Clock;
    logic          Reset;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [3:0]    level;
    logic [1:0]    err;
    logic [1:0]    state_dbg;

    calc_eval_core_if #(.DATA_W(DW)) bus ();

    calc_eval_core #(.DATA_W(DW), .DEPTH(8), .ALU_TIMEOUT(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .bus       (bus.slave),
        .res_valid (res_valid),
        .res_data  (res_data),
        .level     (level),
        .err       (err),
        .state_dbg (state_dbg)
    );

    int tests = 0;
    int fails = 0;
    int starts_seen = 0;
    int starts_exp = 0;
    logic alu_respond = 1'b1;
    logic late_done = 1'b0;
    logic [65:0] exp_q[$];

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic send(input logic [1:0] kind, input logic [1:0] op, input logic [DW-1:0] data);
        int n;
        @(negedge Clock);
        bus.tok_valid = 1'b1;
        bus.tok_kind  = kind;
        bus.tok_op    = op;
        bus.tok_data  = data;
        n = 0;
        while (bus.tok_ready !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        if (bus.tok_ready !== 1'b1) check("send_ready_timeout", {63'd0, bus.tok_ready}, 64'd1);
        @(posedge Clock);
        #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        send(2'b00, 2'b00, v);
    endtask

    task automatic clr();
        send(2'b11, 2'b00, '0);
    endtask

    task automatic expect_alu(input logic [1:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_q.push_back({cmd, a, b});
        starts_exp++;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        @(negedge Clock);
        while (bus.tok_ready !== 1'b1 && cycles < 50) begin
            cycles++;
            @(negedge Clock);
        end
        check("idle_wait", {63'd0, bus.tok_ready}, 64'd1);
    endtask

    task automatic check_stack(input string tag, input logic [3:0] lv, input logic [1:0] e, input logic [DW-1:0] top);
        check({tag, "_level"}, {60'd0, level}, {60'd0, lv});
        check({tag, "_err"}, {62'd0, err}, {62'd0, e});
        check({tag, "_res"}, {32'd0, res_data}, {32'd0, top});
        check({tag, "_rvalid"}, {63'd0, res_valid}, {63'd0, (lv != 0)});
    endtask

    // external ALU model and scoreboard consumer
    initial begin : alu_model
        int cd;
        logic [1:0]    cur_cmd;
        logic [DW-1:0] cur_a;
        logic [DW-1:0] cur_b;
        logic [DW-1:0] res;
        logic [65:0]   item;
        cd = -1;
        res = '0;
        cur_cmd = '0;
        cur_a = '0;
        cur_b = '0;
        bus.al_done = 1'b0;
        bus.al_C = '0;
        forever begin
            @(negedge Clock);
            bus.al_done = 1'b0;
            if (cd == 0) begin
                check("alu_cmd_stable", {62'd0, bus.al_cmd}, {62'd0, cur_cmd});
                check("alu_a_stable", {32'd0, bus.al_A}, {32'd0, cur_a});
                check("alu_b_stable", {32'd0, bus.al_B}, {32'd0, cur_b});
                bus.al_done = 1'b1;
                bus.al_C = res;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (Reset !== 1'b1) cd = -1;
            if (bus.al_start === 1'b1) begin
                starts_seen++;
                if (exp_q.size() == 0) begin
                    check("alu_unexpected_start", 64'd1, 64'd0);
                end else begin
                    item = exp_q.pop_front();
                    check("alu_cmd", {62'd0, bus.al_cmd}, {62'd0, item[65:64]});
                    check("alu_a", {32'd0, bus.al_A}, {32'd0, item[63:32]});
                    check("alu_b", {32'd0, bus.al_B}, {32'd0, item[31:0]});
                end
                if (alu_respond) begin
                    cur_cmd = bus.al_cmd;
                    cur_a = bus.al_A;
                    cur_b = bus.al_B;
                    case (cur_cmd)
                        2'b00: res = cur_a + cur_b;
                        2'b01: res = cur_a - cur_b;
                        2'b10: res = cur_a * cur_b;
                        default: res = cur_a / cur_b;
                    endcase
                    cd = 2;
                end
            end
            if (late_done) begin
                bus.al_done = 1'b1;
                bus.al_C = 32'h5555_5555;
            end
        end
    end

    // directed sequence
    initial begin : stim
        int cyc;
        Reset = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_kind = '0;
        bus.tok_op = '0;
        bus.tok_data = '0;
        #12;
        check_stack("reset", 4'd0, 2'b00, '0);
        check("reset_start", {63'd0, bus.al_start}, 64'd0);
        check("reset_cmd", {62'd0, bus.al_cmd}, 64'd0);
        check("reset_a", {32'd0, bus.al_A}, 64'd0);
        check("reset_b", {32'd0, bus.al_B}, 64'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // 7 5 sub -> 2, ALU answers three cycles after the start pulse
        push(32'd7);
        push(32'd5);
        @(negedge Clock);
        check_stack("push75", 4'd2, 2'b00, 32'd5);
        expect_alu(2'b01, 32'd7, 32'd5);
        send(2'b01, 2'b01, '0);
        @(negedge Clock);
        check("sub_exec_ready", {63'd0, bus.tok_ready}, 64'd0);
        check("sub_exec_start", {63'd0, bus.al_start}, 64'd1);
        @(negedge Clock);
        check("sub_wait_ready", {63'd0, bus.tok_ready}, 64'd0);
        check("sub_wait_start", {63'd0, bus.al_start}, 64'd0);
        wait_idle(cyc);
        check_stack("sub", 4'd1, 2'b00, 32'd2);
        clr();

        // overflow at DEPTH=8
        for (int i = 1; i <= 9; i++) push(32'd100 + i);
        @(negedge Clock);
        check_stack("ovf", 4'd8, 2'b01, 32'd108);
        push(32'd999);
        send(2'b10, 2'b00, '0);
        @(negedge Clock);
        check_stack("ovf_discard", 4'd8, 2'b01, 32'd108);
        clr();
        @(negedge Clock);
        check_stack("ovf_clear", 4'd0, 2'b00, '0);

        // divide by zero, then underflow
        push(32'd4);
        push(32'd0);
        send(2'b01, 2'b11, '0);
        @(negedge Clock);
        check_stack("divzero", 4'd2, 2'b11, 32'd0);
        clr();
        push(32'd1);
        send(2'b01, 2'b00, '0);
        @(negedge Clock);
        check_stack("unf_op", 4'd1, 2'b10, 32'd1);
        clr();

        // mul, div and wrapping add
        push(32'd6);
        push(32'd7);
        expect_alu(2'b10, 32'd6, 32'd7);
        send(2'b01, 2'b10, '0);
        wait_idle(cyc);
        check_stack("mul", 4'd1, 2'b00, 32'd42);
        push(32'd3);
        expect_alu(2'b11, 32'd42, 32'd3);
        send(2'b01, 2'b11, '0);
        wait_idle(cyc);
        check_stack("div", 4'd1, 2'b00, 32'd14);
        push(32'hFFFF_FFFF);
        push(32'd2);
        expect_alu(2'b00, 32'hFFFF_FFFF, 32'd2);
        send(2'b01, 2'b00, '0);
        wait_idle(cyc);
        check_stack("add_wrap", 4'd2, 2'b00, 32'd1);
        clr();

        // ALU timeout: one EXEC cycle plus four WAIT cycles
        push(32'd10);
        push(32'd20);
        alu_respond = 1'b0;
        expect_alu(2'b00, 32'd10, 32'd20);
        send(2'b01, 2'b00, '0);
        wait_idle(cyc);
        check("timeout_busy_cycles", 64'(cyc), 64'd5);
        check_stack("timeout", 4'd2, 2'b11, 32'd20);
        check("timeout_ready", {63'd0, bus.tok_ready}, 64'd1);
        alu_respond = 1'b1;
        clr();

        // negate
        push(32'h0000_0003);
        send(2'b10, 2'b00, '0);
        @(negedge Clock);
        check_stack("neg", 4'd1, 2'b00, 32'hFFFF_FFFD);
        send(2'b10, 2'b00, '0);
        @(negedge Clock);
        check_stack("neg_back", 4'd1, 2'b00, 32'd3);
        clr();
        send(2'b10, 2'b00, '0);
        @(negedge Clock);
        check_stack("neg_unf", 4'd0, 2'b10, '0);
        clr();

        // reset during WAIT, then a late al_done
        push(32'd1);
        push(32'd2);
        alu_respond = 1'b0;
        expect_alu(2'b00, 32'd1, 32'd2);
        send(2'b01, 2'b00, '0);
        @(negedge Clock);
        @(negedge Clock);
        check("pre_reset_state", {62'd0, state_dbg}, 64'd2);
        Reset = 1'b0;
        #1;
        check_stack("rst_wait", 4'd0, 2'b00, '0);
        check("rst_wait_start", {63'd0, bus.al_start}, 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        late_done = 1'b1;
        @(negedge Clock);
        late_done = 1'b0;
        @(negedge Clock);
        check("late_done_level", {60'd0, level}, 64'd0);
        check("late_done_ready", {63'd0, bus.tok_ready}, 64'd1);
        alu_respond = 1'b1;

        // al_done while IDLE is ignored
        push(32'd5);
        late_done = 1'b1;
        @(negedge Clock);
        late_done = 1'b0;
        @(negedge Clock);
        check_stack("idle_done", 4'd1, 2'b00, 32'd5);

        // final report
        repeat (3) @(negedge Clock);
        check("alu_start_count", 64'(starts_seen), 64'(starts_exp));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
